tmr0_wdt_unit: RTL and testbench
================================

# tmr0_wdt_unit

Parametrised timer/watchdog block for the PIC16F5x-class Mini-CPU core. It holds a TMR_W-bit TMR0 counter, a shared prescaler and a watchdog base counter. Configuration comes from OPTION-register fields, exactly as on the PIC16F54. The block sits beside the core datapath: it replaces the bare `tmr0_inc`/`wdtmr` strobes with a self-contained, width-configurable unit that raises overflow and watchdog-timeout pulses.

## Interface
Parameters:
- TMR_W, 8, TMR0 width.
- PS_W, 8, prescaler counter width; opt_ps is $clog2(PS_W) bits wide.
- WDT_W, 12, watchdog base counter width.
- SYNC_STAGES, 2, synchroniser depth for tmr0_inc when TMR0_EXT_SYNC_EN is defined (must be ≥2).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- cyc_tick  in  1  instruction-cycle strobe (Fosc/4); internal TMR0 source.
- tmr0_inc  in  1  external T0CKI pin level.
- opt_t0cs  in  1  0 = cyc_tick source, 1 = tmr0_inc edges.
- opt_t0se  in  1  0 = rising edge of tmr0_inc counts, 1 = falling edge.
- opt_psa  in  1  0 = prescaler assigned to TMR0, 1 = assigned to WDT.
- opt_ps  in  $clog2(PS_W)  prescaler select.
- tmr_we  in  1  TMR0 write strobe.
- tmr_wdata  in  TMR_W  TMR0 write data.
- clrwdt  in  1  CLRWDT instruction strobe.
- wdt_en  in  1  watchdog enable.
- tmr_q  out  TMR_W  current TMR0 value.
- tmr_ovf  out  1  one-cycle pulse on TMR0 wrap from all-ones to 0.
- wdtmr  out  1  one-cycle watchdog timeout pulse.

## Operation
- Reset (rst=0): tmr_q=0, tmr_ovf=0, wdtmr=0; prescaler, WDT counter, synchroniser, edge and inhibit state all cleared. Reset acts immediately, including mid-count and mid-inhibit.
- Source event: opt_t0cs=0 uses cyc_tick. opt_t0cs=1 uses one selected edge of the synchronised tmr0_inc (polarity set by opt_t0se).
- opt_psa=0: each source event advances the prescaler. TMR0 increments once per 2^(opt_ps+1) source events, i.e. when prescaler bits [opt_ps:0] roll over to zero. If opt_ps+1 > PS_W, the ratio saturates at 2^PS_W.
- opt_psa=1: TMR0 increments on every source event.
- WDT: the base counter increments every clk while wdt_en=1 and holds while wdt_en=0. Its wrap is the WDT event.
  - opt_psa=1: each WDT event advances the prescaler; wdtmr pulses once per 2^opt_ps WDT events (opt_ps=0 → every wrap).
  - opt_psa=0: wdtmr pulses on every WDT wrap.
- TMR0 arithmetic: modulo 2^TMR_W. tmr_ovf pulses in the cycle tmr_q becomes 0 via increment. A write of 0 does not pulse tmr_ovf.
- tmr_we: tmr_q=tmr_wdata on the next edge. The 2 following clk cycles inhibit TMR0 increments; events in those cycles are dropped. Clears the prescaler if opt_psa=0.
- clrwdt: clears the WDT base counter. Clears the prescaler if opt_psa=1.
- Any change of opt_psa or opt_ps, detected against a registered copy, clears the prescaler on the next edge.
- Simultaneous events:
  - tmr_we with increment → write wins, no tmr_ovf.
  - clrwdt with WDT wrap → clrwdt wins, no wdtmr.
  - Prescaler clear with prescaler advance → clear wins.

## Timing
- tmr_q is registered; it reflects a write 1 cycle after tmr_we.
- Internal source: the tmr_q increment is visible 1 cycle after the qualifying cyc_tick.
- External source: the tmr_q increment is visible SYNC_STAGES+1 cycles after the tmr0_inc edge with the sync macro defined, 1 cycle without it.
- tmr_ovf and wdtmr are registered and asserted in the same cycle as the causing counter update.
- Input pulses shorter than 1 clk on tmr0_inc are not guaranteed to count.

## Configuration
- TMR0_EXT_SYNC_EN defined: tmr0_inc passes through a SYNC_STAGES flop synchroniser before edge detection. Safe for an asynchronous pin.
- TMR0_EXT_SYNC_EN undefined: tmr0_inc is treated as synchronous to clk and edge-detected with a single flop. External latency is 1 cycle and the synchroniser flops are removed.

## Test plan
- Internal, no prescale: opt_t0cs=0, opt_psa=1, cyc_tick every 4 clk from reset, 256 ticks → tmr_q wraps 0xFF→0x00 with exactly one tmr_ovf pulse.
- Prescaler: opt_psa=0, opt_ps=2, 32 cyc_ticks → tmr_q=4. Changing opt_ps mid-count clears the prescaler, so the next increment needs a full 8 ticks.
- Write/inhibit: tmr_we with tmr_wdata=0xFE while cyc_tick is held high every clk → tmr_q=0xFE, then 0xFE for 2 more cycles, 0xFF, 0x00+tmr_ovf.
- External edge: opt_t0cs=1, opt_t0se=1, opt_psa=1, 5 falling edges on tmr0_inc → tmr_q=5, each step exactly SYNC_STAGES+1 clk after its edge; rising edges ignored.
- Watchdog: WDT_W=4, opt_psa=1, opt_ps=1, wdt_en=1 → wdtmr at clk 32 after reset release. clrwdt at clk 31 suppresses it and restarts the count. With opt_psa=0, wdtmr fires every 16 clk.
- Reset mid-operation: assert rst=0 with tmr_q=0x80 in the middle of an inhibit window → all outputs 0 immediately. After release, counting resumes from 0 with no stale inhibit.

Source files
------------

// File: rtl/tmr0_wdt_unit.sv
// TMR0 / watchdog unit for the PIC16F5x-class core: TMR0 counter, shared prescaler, WDT base counter.
// Define TMR0_EXT_SYNC_EN to pass the T0CKI pin through a SYNC_STAGES-flop synchroniser.
module tmr0_wdt_unit #(
  parameter int TMR_W       = 8,
  parameter int PS_W        = 8,
  parameter int WDT_W       = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cyc_tick,
  input  logic                    tmr0_inc,
  input  logic                    opt_t0cs,
  input  logic                    opt_t0se,
  input  logic                    opt_psa,
  input  logic [$clog2(PS_W)-1:0] opt_ps,
  input  logic                    tmr_we,
  input  logic [TMR_W-1:0]        tmr_wdata,
  input  logic                    clrwdt,
  input  logic                    wdt_en,
  output logic [TMR_W-1:0]        tmr_q,
  output logic                    tmr_ovf,
  output logic                    wdtmr
);

  localparam int SEL_W = $clog2(PS_W);

  if (SYNC_STAGES < 2) begin : g_sync_stages_check
    $error("tmr0_wdt_unit: SYNC_STAGES must be at least 2");
  end

  // ---------------------------------------------------------------------------
  // External clock pin: optional synchroniser, then a single edge-detect flop
  // ---------------------------------------------------------------------------
  logic ext_lvl;
  logic ext_prev;
  logic ext_edge;
  logic src_evt;

`ifdef TMR0_EXT_SYNC_EN
  logic [SYNC_STAGES-1:0] sync_q;

  // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], tmr0_inc};
  end

  assign ext_lvl = sync_q[SYNC_STAGES-1];
`else
  assign ext_lvl = tmr0_inc;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ext_prev <= 1'b0;
    else      ext_prev <= ext_lvl;
  end

  assign ext_edge = opt_t0se ? (ext_prev & ~ext_lvl) : (~ext_prev & ext_lvl);
  assign src_evt  = opt_t0cs ? ext_edge : cyc_tick;

  // ---------------------------------------------------------------------------
  // Write-inhibit sequencer: the two cycles after a TMR0 write drop increments
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    INH_IDLE,
    INH_HOLD2,
    INH_HOLD1
  } inh_state_e;

  inh_state_e inh_state;
  inh_state_e inh_next;
  logic       inhibit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) inh_state <= INH_IDLE;
    else      inh_state <= inh_next;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    inh_next = inh_state;
    inhibit  = 1'b0;
    case (inh_state)
      INH_IDLE:  inh_next = INH_IDLE;
      INH_HOLD2: begin
        inhibit  = 1'b1;
        inh_next = INH_HOLD1;
      end
      INH_HOLD1: begin
        inhibit  = 1'b1;
        inh_next = INH_IDLE;
      end
      default:   inh_next = INH_IDLE;
    endcase
    if (tmr_we) inh_next = INH_HOLD2;
  end

  logic tmr_evt;
  assign tmr_evt = src_evt & ~inhibit;

  // ---------------------------------------------------------------------------
  // Configuration shadow: any OPTION change restarts the prescaler
  // ---------------------------------------------------------------------------
  logic             cfg_psa_q;
  logic [SEL_W-1:0] cfg_ps_q;
  logic             cfg_chg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_psa_q <= 1'b0;
      cfg_ps_q  <= '0;
    end else begin
      cfg_psa_q <= opt_psa;
      cfg_ps_q  <= opt_ps;
    end
  end

  assign cfg_chg = (opt_psa != cfg_psa_q) || (opt_ps != cfg_ps_q);

  // ---------------------------------------------------------------------------
  // Watchdog base counter
  // ---------------------------------------------------------------------------
  logic [WDT_W-1:0] wdt_cnt;
  logic             wdt_wrap;

  assign wdt_wrap = wdt_en & (&wdt_cnt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        wdt_cnt <= '0;
    else if (clrwdt) wdt_cnt <= '0;
    else if (wdt_en) wdt_cnt <= wdt_cnt + 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Shared prescaler
  // ---------------------------------------------------------------------------
  // Mask of the low (sel + extra) bits, saturating at the full prescaler width.
  function automatic logic [PS_W-1:0] low_mask(input logic [SEL_W-1:0] sel, input logic extra);
    logic [PS_W-1:0] m;
    int              n;
    m = '0;
    n = 32'(sel) + 32'(extra);
    for (int i = 0; i < PS_W; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

  logic [PS_W-1:0] ps_cnt;
  logic [PS_W-1:0] ps_inc;
  logic [PS_W-1:0] ps_mask;
  logic            ps_clr;
  logic            ps_adv;
  logic            ps_fire;

  // TMR0 divides by 2^(opt_ps+1); the watchdog divides by 2^opt_ps.
  assign ps_mask = low_mask(opt_ps, ~opt_psa);
  assign ps_inc  = ps_cnt + 1'b1;
  assign ps_clr  = cfg_chg | (tmr_we & ~opt_psa) | (clrwdt & opt_psa);
  assign ps_adv  = opt_psa ? (wdt_wrap & ~clrwdt) : tmr_evt;
  assign ps_fire = ps_adv & ~ps_clr & ((ps_inc & ps_mask) == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        ps_cnt <= '0;
    else if (ps_clr) ps_cnt <= '0;
    else if (ps_adv) ps_cnt <= ps_inc;
  end

  // ---------------------------------------------------------------------------
  // TMR0 register and output pulses
  // ---------------------------------------------------------------------------
  logic tmr_inc;
  logic wdt_fire;

  assign tmr_inc  = opt_psa ? tmr_evt : ps_fire;
  assign wdt_fire = opt_psa ? ps_fire : (wdt_wrap & ~clrwdt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmr_q   <= '0;
      tmr_ovf <= 1'b0;
    end else if (tmr_we) begin
      tmr_q   <= tmr_wdata;
      tmr_ovf <= 1'b0;
    end else if (tmr_inc) begin
      tmr_q   <= tmr_q + 1'b1;
      tmr_ovf <= &tmr_q;
    end else begin
      tmr_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wdtmr <= 1'b0;
    else      wdtmr <= wdt_fire;
  end

endmodule

// File: tb/tb_tmr0_wdt_unit.sv
// Self-checking bench for tmr0_wdt_unit: directed scenarios plus randomized traffic,
// all compared every cycle against an arithmetic model of the timer/watchdog rules.
module tb_tmr0_wdt_unit;

  localparam int TMR_W       = 8;
  localparam int PS_W        = 8;
  localparam int WDT_W       = 4;
  localparam int SYNC_STAGES = 2;
  localparam int SEL_W       = $clog2(PS_W);
`ifdef TMR0_EXT_SYNC_EN
  localparam int LAT = SYNC_STAGES;
`else
  localparam int LAT = 0;
`endif

  logic             clk       = 1'b0;
  logic             rst       = 1'b1;
  logic             cyc_tick  = 1'b0;
  logic             tmr0_inc  = 1'b0;
  logic             opt_t0cs  = 1'b0;
  logic             opt_t0se  = 1'b0;
  logic             opt_psa   = 1'b0;
  logic [SEL_W-1:0] opt_ps    = '0;
  logic             tmr_we    = 1'b0;
  logic [TMR_W-1:0] tmr_wdata = '0;
  logic             clrwdt    = 1'b0;
  logic             wdt_en    = 1'b0;
  logic [TMR_W-1:0] tmr_q;
  logic             tmr_ovf;
  logic             wdtmr;

  always #5 clk = ~clk;

  tmr0_wdt_unit #(
    .TMR_W(TMR_W), .PS_W(PS_W), .WDT_W(WDT_W), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .rst(rst), .cyc_tick(cyc_tick), .tmr0_inc(tmr0_inc),
    .opt_t0cs(opt_t0cs), .opt_t0se(opt_t0se), .opt_psa(opt_psa), .opt_ps(opt_ps),
    .tmr_we(tmr_we), .tmr_wdata(tmr_wdata), .clrwdt(clrwdt), .wdt_en(wdt_en),
    .tmr_q(tmr_q), .tmr_ovf(tmr_ovf), .wdtmr(wdtmr)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_tmr, m_ps_events, m_wdt_cnt, m_since_we, m_prev_ps;
  bit m_prev_psa, m_lvl_prev, exp_ovf, exp_wdt;
  bit pin_hist [8];

  function automatic int pow2_sat(input int n);
    return (n >= PS_W) ? (1 << PS_W) : (1 << n);
  endfunction

  task automatic model_reset();
    m_tmr = 0; m_ps_events = 0; m_wdt_cnt = 0; m_since_we = 2;
    m_prev_ps = 0; m_prev_psa = 0; m_lvl_prev = 0; exp_ovf = 0; exp_wdt = 0;
    for (int i = 0; i < 8; i++) pin_hist[i] = 0;
  endtask

  // Applies the rules for one rising edge using the inputs currently driven.
  task automatic model_edge();
    bit lvl, ext_evt, src, inhibited, cfg_chg, ps_clear, wdt_wrap, tmr_event, adv, fire, tmr_incr;
    int ratio, idx;
    if (LAT == 0) lvl = tmr0_inc;
    else begin
      idx = LAT - 1;
      lvl = pin_hist[idx];
    end
    ext_evt   = opt_t0se ? (m_lvl_prev && !lvl) : (!m_lvl_prev && lvl);
    src       = opt_t0cs ? ext_evt : cyc_tick;
    inhibited = (m_since_we < 2);
    cfg_chg   = (opt_psa != m_prev_psa) || (int'(opt_ps) != m_prev_ps);
    ps_clear  = cfg_chg || (tmr_we && !opt_psa) || (clrwdt && opt_psa);
    wdt_wrap  = wdt_en && (m_wdt_cnt == (1 << WDT_W) - 1);
    tmr_event = src && !inhibited;
    adv       = opt_psa ? (wdt_wrap && !clrwdt) : tmr_event;
    ratio     = opt_psa ? pow2_sat(int'(opt_ps)) : pow2_sat(int'(opt_ps) + 1);
    fire      = adv && !ps_clear && (((m_ps_events + 1) % ratio) == 0);
    tmr_incr  = opt_psa ? tmr_event : fire;

    exp_ovf = 0;
    if (tmr_we) m_tmr = int'(tmr_wdata);
    else if (tmr_incr) begin
      m_tmr   = (m_tmr + 1) % (1 << TMR_W);
      exp_ovf = (m_tmr == 0);
    end
    exp_wdt = opt_psa ? fire : (wdt_wrap && !clrwdt);

    if (ps_clear) m_ps_events = 0;
    else if (adv) m_ps_events = m_ps_events + 1;
    if (clrwdt) m_wdt_cnt = 0;
    else if (wdt_en) m_wdt_cnt = (m_wdt_cnt + 1) % (1 << WDT_W);
    m_since_we = tmr_we ? 0 : ((m_since_we < 2) ? m_since_we + 1 : 2);
    m_prev_psa = opt_psa;
    m_prev_ps  = int'(opt_ps);
    m_lvl_prev = lvl;
    for (int i = 7; i > 0; i--) pin_hist[i] = pin_hist[i-1];
    pin_hist[0] = tmr0_inc;
  endtask

  // Called at a falling edge with inputs set; returns at the next falling edge.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("tmr_q", 32'(tmr_q), 32'(m_tmr));
    check("tmr_ovf", 32'(tmr_ovf), 32'(exp_ovf));
    check("wdtmr", 32'(wdtmr), 32'(exp_wdt));
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int ovf_seen, first, p1, p2, lat, k;

    // Reset state
    #2 rst = 1'b0;
    model_reset();
    @(negedge clk);
    check("reset_tmr_q", 32'(tmr_q), 32'h0);
    check("reset_tmr_ovf", 32'(tmr_ovf), 32'h0);
    check("reset_wdtmr", 32'(wdtmr), 32'h0);

    // Internal source, no prescale: 256 ticks wrap TMR0 once
    opt_psa = 1'b1; opt_ps = '0; opt_t0cs = 1'b0; wdt_en = 1'b0;
    do_reset();
    ovf_seen = 0;
    for (int t = 0; t < 256; t++) begin
      cyc_tick = 1'b1; step(); ovf_seen += int'(tmr_ovf);
      cyc_tick = 1'b0;
      repeat (3) begin step(); ovf_seen += int'(tmr_ovf); end
    end
    check("wrap_tmr_q", 32'(tmr_q), 32'h0);
    check("wrap_ovf_count", 32'(ovf_seen), 32'd1);

    // Prescaler 1:8 and restart on an opt_ps change
    opt_psa = 1'b0; opt_ps = 3'd2;
    do_reset();
    step();
    for (int t = 0; t < 32; t++) begin
      cyc_tick = 1'b1; step(); cyc_tick = 1'b0; step();
    end
    check("ps_div8", 32'(tmr_q), 32'd4);
    for (int t = 0; t < 5; t++) begin
      cyc_tick = 1'b1; step(); cyc_tick = 1'b0; step();
    end
    opt_ps = 3'd3; step();
    opt_ps = 3'd2; step();
    for (int t = 0; t < 7; t++) begin
      cyc_tick = 1'b1; step(); cyc_tick = 1'b0; step();
    end
    check("ps_restart_7", 32'(tmr_q), 32'd4);
    cyc_tick = 1'b1; step(); cyc_tick = 1'b0; step();
    check("ps_restart_8", 32'(tmr_q), 32'd5);

    // Write and two-cycle inhibit with cyc_tick held high
    opt_psa = 1'b1; step();
    cyc_tick = 1'b1; tmr_we = 1'b1; tmr_wdata = 8'hFE; step();
    check("we_value", 32'(tmr_q), 32'hFE);
    tmr_we = 1'b0; step();
    check("inhibit_1", 32'(tmr_q), 32'hFE);
    step();
    check("inhibit_2", 32'(tmr_q), 32'hFE);
    step();
    check("after_inhibit", 32'(tmr_q), 32'hFF);
    step();
    check("wrap_after_we", 32'(tmr_q), 32'h00);
    check("ovf_after_we", 32'(tmr_ovf), 32'h1);

    // External falling edges
    cyc_tick = 1'b0; opt_t0cs = 1'b1; opt_t0se = 1'b1;
    tmr_we = 1'b1; tmr_wdata = 8'h00; step();
    tmr_we = 1'b0;
    repeat (3) step();
    for (int p = 0; p < 5; p++) begin
      k = int'(tmr_q);
      tmr0_inc = 1'b1;
      repeat (4) step();
      check("rise_ignored", 32'(tmr_q), 32'(k));
      tmr0_inc = 1'b0;
      lat = -1;
      for (int e = 1; e <= 6; e++) begin
        step();
        if (lat < 0 && int'(tmr_q) != k) lat = e;
      end
      check("ext_latency", 32'(lat), 32'(LAT + 1));
    end
    check("ext_count", 32'(tmr_q), 32'd5);

    // Watchdog through the prescaler, clrwdt suppression, and direct wraps
    opt_t0cs = 1'b0; opt_t0se = 1'b0; opt_psa = 1'b1; opt_ps = 3'd1; wdt_en = 1'b1;
    do_reset();
    first = -1;
    for (int e = 1; e <= 40; e++) begin
      step();
      if (wdtmr && first < 0) first = e;
    end
    check("wdt_first", 32'(first), 32'd32);
    do_reset();
    first = -1;
    for (int e = 1; e <= 80; e++) begin
      clrwdt = (e == 31);
      step();
      if (wdtmr && first < 0) first = e;
    end
    clrwdt = 1'b0;
    check("wdt_clrwdt", 32'(first), 32'd63);
    opt_psa = 1'b0; opt_ps = '0;
    do_reset();
    p1 = -1; p2 = -1;
    for (int e = 1; e <= 40; e++) begin
      step();
      if (wdtmr) begin
        if (p1 < 0) p1 = e;
        else if (p2 < 0) p2 = e;
      end
    end
    check("wdt_direct_first", 32'(p1), 32'd16);
    check("wdt_direct_period", 32'(p2 - p1), 32'd16);

    // Reset in the middle of an inhibit window
    wdt_en = 1'b0; opt_psa = 1'b1;
    tmr_we = 1'b1; tmr_wdata = 8'h80; step();
    tmr_we = 1'b0;
    check("pre_reset_q", 32'(tmr_q), 32'h80);
    #2 rst = 1'b0;
    #1;
    check("async_rst_q", 32'(tmr_q), 32'h0);
    check("async_rst_ovf", 32'(tmr_ovf), 32'h0);
    check("async_rst_wdt", 32'(wdtmr), 32'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    cyc_tick = 1'b1; step();
    check("resume_no_inhibit", 32'(tmr_q), 32'h1);

    // Randomized traffic against the model
    cyc_tick = 1'b0; opt_ps = 3'd1; wdt_en = 1'b1;
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      cyc_tick  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) tmr0_inc = ~tmr0_inc;
      tmr_we    = ($urandom_range(0, 40) == 0);
      tmr_wdata = ($urandom_range(0, 2) == 0) ? 8'(8'hFC + $urandom_range(0, 3)) : 8'($urandom);
      clrwdt    = ($urandom_range(0, 60) == 0);
      wdt_en    = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 150) == 0) opt_psa = ~opt_psa;
      if ($urandom_range(0, 150) == 0) opt_ps = SEL_W'($urandom);
      if ($urandom_range(0, 200) == 0) opt_t0cs = ~opt_t0cs;
      if ($urandom_range(0, 200) == 0) opt_t0se = ~opt_t0se;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
